// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INSN_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;

  // Redirect targets and the reset PC are forced to word alignment.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/flush and an occupancy count.
// Head entry is read straight from registered storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       wr_entry,
  output fetch_entry_t       head_entry,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t             mem [DEPTH];
  logic [PTR_W-1:0]         head_ptr;
  logic [PTR_W-1:0]         tail_ptr;

  assign head_entry = mem[head_ptr];

  // Storage is cleared on reset so an empty head never reads as X.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= wr_entry;
        tail_ptr      <= tail_ptr + PTR_W'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst || flush)
                                   !(pop && count == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
                                  !(push && !pop && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, drives the icache port and
// queues {pc, insn} pairs for decode. Optional same-cycle bypass: FETCH_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_rd_req,
  input  logic              ic_rd_wait,
  input  logic [INSN_W-1:0] ic_rd_data,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmppc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSN_W-1:0] out_insn,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head_entry;
  fetch_entry_t      wr_entry;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fetch_ok;

  assign ic_rd_addr = pc;

  // Request/handshake decode. A full queue may still fetch when it pops this cycle.
  always_comb begin
    fifo_pop  = (count != '0) && out_ready;
    ic_rd_req = !rst && !jmp && ((count < CNT_W'(DEPTH)) || fifo_pop);
    fetch_ok  = ic_rd_req && !ic_rd_wait;
    wr_entry  = '{pc: pc, insn: ic_rd_data};
`ifdef FETCH_BYPASS_EN
    // Empty queue: a hit goes straight to decode and is only queued if not taken.
    if ((count == '0) && fetch_ok) begin
      out_valid = 1'b1;
      out_insn  = ic_rd_data;
      out_pc    = pc;
      fifo_push = !out_ready;
    end else begin
      out_valid = (count != '0);
      out_insn  = head_entry.insn;
      out_pc    = head_entry.pc;
      fifo_push = fetch_ok;
    end
`else
    out_valid = (count != '0);
    out_insn  = head_entry.insn;
    out_pc    = head_entry.pc;
    fifo_push = fetch_ok;
`endif
  end

  // PC holds through icache waits so the fill sees a stable address.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= align_pc(RESET_PC);
    end else if (jmp) begin
      pc <= align_pc(jmppc);
    end else if (fetch_ok) begin
      pc <= pc + PC_STEP;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .flush      (jmp),
    .wr_entry   (wr_entry),
    .head_entry (head_entry),
    .count      (count)
  );

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the instruction cache.
- Owns the fetch PC and presents it to the cache port as an address/request pair.
- Captures each returned instruction word into a small FIFO and hands {pc, insn} pairs to decode with a valid/ready handshake.
- Handles branch redirects by flushing the FIFO and dropping any in-flight fetch.

Parameters:
- RESET_PC, 32'h00000000, fetch PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, FIFO entries; power of two, 2..8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ic_rd_addr  out  32  fetch address to icache; driven straight from the PC register.
- ic_rd_req  out  1  fetch request to icache.
- ic_rd_wait  in  1  icache miss/stall, combinational from ic_rd_addr.
- ic_rd_data  in  32  instruction word; valid in any cycle with ic_rd_req=1 and ic_rd_wait=0.
- jmp  in  1  redirect strobe from execute.
- jmppc  in  32  redirect target.
- out_valid  out  1  out_insn/out_pc hold a valid instruction.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_insn  out  32  instruction word.
- out_pc  out  32  address of out_insn.

Behaviour:
- Reset: pc=RESET_PC, FIFO empty, count=0, out_valid=0, ic_rd_req=0, out_insn=0, out_pc=0.
- Reset has priority over every other event.
- Request generation:
  - ic_rd_addr = pc at all times.
  - ic_rd_req = !rst && !jmp && (count < DEPTH || pop).
  - pop = out_valid && out_ready. A full FIFO may therefore fetch in the same cycle it pops.
- Fetch completion: fetch_ok = ic_rd_req && !ic_rd_wait.
  - On fetch_ok: push {pc, ic_rd_data}; pc <= pc+4, wrapping modulo 2^32.
  - While ic_rd_wait=1: pc holds, nothing is pushed, and the request stays asserted with a stable address (the icache fill relies on a stable address).
- Output: out_valid = (count != 0). out_insn/out_pc come from the FIFO head, as registered storage.
  - Latency from fetch_ok to out_valid: 1 cycle.
  - Both the push and the pop side use the single cycle-by-cycle handshake above.
- Simultaneous push and pop: count unchanged; head and tail pointers both advance, each wrapping modulo DEPTH.
- Redirect: when jmp=1,
  - pc <= {jmppc[31:2], 2'b00};
  - FIFO cleared (count=0, pointers reset);
  - ic_rd_req=0 that cycle, so no push occurs even if the cache hit;
  - any pop in that cycle is still counted by decode, but the FIFO state is discarded.
  - First new fetch is issued the cycle after jmp; the first redirected instruction reaches out_valid 2 cycles after jmp at the earliest.
- Back-to-back jmp: the last one wins; no fetches are issued while jmp is held.
- Full FIFO with out_ready=0: ic_rd_req=0, pc holds, no data lost.
- Empty FIFO: out_valid=0; out_insn/out_pc are don't-care but must not produce X in simulation.
- Invariant: count never exceeds DEPTH and never underflows (enforced by assertion in simulation).

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When count==0 and fetch_ok, the word is presented combinationally the same cycle: out_valid=1, out_insn=ic_rd_data, out_pc=pc.
  - If out_ready=1 in that cycle the word is consumed and not pushed; otherwise it is pushed.
  - Fetch-to-decode latency becomes 0 cycles. During jmp the bypass is suppressed.
- Undefined: all data passes through the FIFO; latency 1 cycle as above.

Decomposition:
- Shared package (fetch_pkg):
  - INSN_W=32, ADDR_W=32;
  - fetch_entry_t struct {pc[31:0], insn[31:0]};
  - PC_STEP=4.
- One natural sub-module, fetch_fifo: parameterised DEPTH sync FIFO of fetch_entry_t with push/pop/flush and count. fetch_queue instantiates it and adds the PC/request/redirect logic.

Test Plan:
- Reset with RESET_PC=32'h100; cache always hits, out_ready=1 -> ic_rd_addr sequence 100,104,108...; out_pc matches one cycle later; no gaps.
- out_ready=0 with always-hit, DEPTH=2 -> exactly 2 pushes (100,104), then ic_rd_req=0 and pc=108 held. Raise out_ready -> fetch resumes at 108 with no duplicates or drops.
- ic_rd_wait=1 for 16 cycles at addr 200 -> ic_rd_addr stays 200 and ic_rd_req stays 1 throughout. When wait drops, insn at 200 is pushed and pc=204.
- FIFO holds 300,304; pulse jmp with jmppc=32'h503 -> FIFO empty next cycle, ic_rd_req=0 during jmp, next fetch address 500. First out_pc=500, with no stale 300/304/308 ever presented.
- pc=32'hFFFFFFFC with a hit -> next ic_rd_addr=0; out_pc=FFFFFFFC.
- FETCH_BYPASS_EN defined, empty FIFO, hit at 40, out_ready=1 -> out_valid=1 with out_pc=40 in the same cycle, and count stays 0.
